// File: rtl/fm_pkg.sv
// fm_pkg: shared widths, constants, config record and quarter-sine table generator for the FM modulator
package fm_pkg;

    localparam int PHASE_W     = 32;
    localparam int DATA_W      = 10;
    localparam int KF_W        = 16;
    localparam int LUT_AW      = 8;
    localparam int MAG_W       = DATA_W - 1;
    localparam int DEV_W       = DATA_W + KF_W + 1;
    localparam int MID_SCALE   = 512;
    localparam int DDS_LATENCY = 7;

    typedef struct packed {
        logic [PHASE_W-1:0] fc;
        logic [KF_W-1:0]    kf;
        logic [PHASE_W-1:0] tone;
    } cfg_t;

    // round(511*sin(pi/2*(i+0.5)/256)) using a Q30 Taylor series so the table folds at elaboration
    function automatic logic [MAG_W-1:0] qsin(input int i);
        longint x, x2, t, s;
        x  = (64'sd3373259426 * longint'(2 * i + 1)) / 1024;
        x2 = (x * x) >>> 30;
        t  = x;
        s  = x;
        for (int k = 1; k <= 8; k++) begin
            t = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s = s + t;
        end
        return MAG_W'((s * 511 + (64'sd1 <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: quarter-wave sine magnitude ROM with a registered read port
module sine_qlut
    import fm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr,
    output logic [MAG_W-1:0]  mag
);

    logic [MAG_W-1:0] rom [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [MAG_W-1:0] V = qsin(i);
        assign rom[i] = V;
    end

    // one-cycle synchronous table read
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mag <= '0;
        else        mag <= rom[addr];

endmodule

// File: rtl/fm_mod.sv
// fm_mod: DDS FM modulator with double-buffered config applied at carrier phase wraps
module fm_mod
    import fm_pkg::*;
(
    input  logic               clk_32m,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  mod_in,
    input  logic               mode,
    input  logic [PHASE_W-1:0] fc_word,
    input  logic [KF_W-1:0]    kf,
    input  logic [PHASE_W-1:0] tone_word,
    input  logic               cfg_load,
    output logic               cfg_ack,
    output logic [DATA_W-1:0]  dac_data,
    output logic               dac_valid,
    output logic               phase_wrap
);

    cfg_t                      pend, act;
    logic                      pend_flag, apply;
    logic [PHASE_W-1:0]        tone_acc;
    logic [DATA_W-1:0]         tri_val, sample;
    logic signed [DATA_W:0]    s_q;
    logic signed [DEV_W-1:0]   dev_q, prod;
    logic [PHASE_W-1:0]        inc_q, acc_q;
    logic [PHASE_W:0]          sum;
    logic [1:0]                q4, q5;
    logic [LUT_AW-1:0]         idx4;
    logic [MAG_W-1:0]          mag;
    logic [DDS_LATENCY-1:0]    fill;

    // an active carrier of zero never wraps, so pending settings are taken at once in that case
    assign apply   = pend_flag && (phase_wrap || act.fc == '0);
    assign tri_val = tone_acc[PHASE_W-1] ? ~tone_acc[PHASE_W-2 -: DATA_W] : tone_acc[PHASE_W-2 -: DATA_W];
    assign sample  = mode ? tri_val : mod_in;
    assign prod    = DEV_W'(s_q) * DEV_W'($signed({1'b0, act.kf}));
    assign sum     = {1'b0, acc_q} + {1'b0, inc_q};
    assign dac_valid = fill[DDS_LATENCY-1];

    // pending/active config double buffer and acknowledge pulse
    always_ff @(posedge clk_32m or negedge rst_n)
        if (!rst_n) begin
            pend      <= '0;
            act       <= '0;
            pend_flag <= 1'b0;
            cfg_ack   <= 1'b0;
        end else begin
            if (cfg_load) pend <= '{fc: fc_word, kf: kf, tone: tone_word};
            if (apply) act <= pend;
            pend_flag <= cfg_load || (pend_flag && !apply);
            cfg_ack   <= apply;
        end

    // internal triangle test-tone phase accumulator
    always_ff @(posedge clk_32m or negedge rst_n)
        if (!rst_n) tone_acc <= '0;
        else        tone_acc <= tone_acc + act.tone;

    // seven-stage modulation, phase accumulation and sine reconstruction pipeline
    always_ff @(posedge clk_32m or negedge rst_n)
        if (!rst_n) begin
            s_q        <= '0;
            dev_q      <= '0;
            inc_q      <= '0;
            acc_q      <= '0;
            phase_wrap <= 1'b0;
            q4         <= '0;
            idx4       <= '0;
            q5         <= '0;
            dac_data   <= DATA_W'(MID_SCALE);
        end else begin
            s_q        <= {1'b0, sample} - (DATA_W+1)'(MID_SCALE);
            dev_q      <= prod;
            inc_q      <= act.fc + {{(PHASE_W-DEV_W){dev_q[DEV_W-1]}}, dev_q};
            acc_q      <= sum[PHASE_W-1:0];
            phase_wrap <= sum[PHASE_W];
            q4         <= acc_q[PHASE_W-1 -: 2];
            idx4       <= acc_q[PHASE_W-2] ? ~acc_q[PHASE_W-3 -: LUT_AW] : acc_q[PHASE_W-3 -: LUT_AW];
            q5         <= q4;
            dac_data   <= q5[1] ? DATA_W'(MID_SCALE) - {1'b0, mag} : DATA_W'(MID_SCALE) + {1'b0, mag};
        end

    // output-valid fill tracker, one bit per pipeline stage
    always_ff @(posedge clk_32m or negedge rst_n)
        if (!rst_n) fill <= '0;
        else        fill <= {fill[DDS_LATENCY-2:0], 1'b1};

    sine_qlut u_lut (
        .clk   (clk_32m),
        .rst_n (rst_n),
        .addr  (idx4),
        .mag   (mag)
    );

endmodule

// File: tb/tb_fm_mod.sv
// tb_fm_mod: directed and randomized checks of fm_mod against a cycle-indexed arithmetic reference
module tb_fm_mod;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  mod_in;
    logic        mode;
    logic [31:0] fc_word;
    logic [15:0] kf;
    logic [31:0] tone_word;
    logic        cfg_load;
    logic        cfg_ack;
    logic [9:0]  dac_data;
    logic        dac_valid;
    logic        phase_wrap;

    always #5 clk = ~clk;

    fm_mod dut (
        .clk_32m    (clk),
        .rst_n      (rst_n),
        .mod_in     (mod_in),
        .mode       (mode),
        .fc_word    (fc_word),
        .kf         (kf),
        .tone_word  (tone_word),
        .cfg_load   (cfg_load),
        .cfg_ack    (cfg_ack),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .phase_wrap (phase_wrap)
    );

    localparam int N = 16384;

    int          checks = 0;
    int          errors = 0;
    int          n;
    int          s_h   [N];
    int          kf_h  [N];
    logic [31:0] fc_h  [N];
    logic [31:0] tw_h  [N];
    logic [31:0] tone_h[N];
    logic [31:0] acc_h [N];
    bit          wrap_h[N];
    bit          pend_on;
    bit          ack_e;
    logic [31:0] p_fc, p_tw;
    int          p_kf;
    int          wraps, acks, bad, total;

    function automatic int sv(int i);
        return i < 0 ? 0 : s_h[i];
    endfunction

    function automatic int kv(int i);
        return i < 0 ? 0 : kf_h[i];
    endfunction

    function automatic logic [31:0] fcv(int i);
        return i < 0 ? 32'd0 : fc_h[i];
    endfunction

    function automatic logic [31:0] accv(int i);
        return i < 0 ? 32'd0 : acc_h[i];
    endfunction

    // ideal DAC code for a phase: 1024 equal phase bins sampled at bin centres
    function automatic int dds(logic [31:0] a);
        real th, v;
        int  m;
        th = 2.0 * 3.141592653589793 * (real'(int'(a >> 22)) + 0.5) / 1024.0;
        v  = $sin(th);
        m  = $rtoi(511.0 * (v < 0.0 ? -v : v) + 0.5);
        return v < 0.0 ? 512 - m : 512 + m;
    endfunction

    function automatic int tri_of(logic [31:0] t);
        int p;
        p = int'((t >> 21) & 32'd1023);
        return t[31] ? 1023 - p : p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s at n=%0d: got %0d, expected %0d", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        s_h[0] = 0; kf_h[0] = 0; fc_h[0] = 0; tw_h[0] = 0;
        tone_h[0] = 0; acc_h[0] = 0; wrap_h[0] = 0;
        pend_on = 0; ack_e = 0; p_fc = 0; p_tw = 0; p_kf = 0;
    endtask

    // advance the reference by one clock edge using the inputs present at that edge
    task automatic model_step();
        int          smp;
        longint      dev, sum;
        logic [31:0] inc;
        bit          apply;
        n++;
        smp       = mode ? tri_of(tone_h[n-1]) : int'(mod_in);
        s_h[n]    = smp - 512;
        tone_h[n] = tone_h[n-1] + tw_h[n-1];
        dev       = longint'(sv(n-3)) * longint'(kv(n-3));
        inc       = fcv(n-2) + 32'(dev);
        sum       = 64'(accv(n-1)) + 64'(inc);
        acc_h[n]  = sum[31:0];
        wrap_h[n] = sum[32];
        apply     = pend_on && (wrap_h[n-1] || fc_h[n-1] == 32'd0);
        fc_h[n]   = apply ? p_fc : fc_h[n-1];
        kf_h[n]   = apply ? p_kf : kf_h[n-1];
        tw_h[n]   = apply ? p_tw : tw_h[n-1];
        ack_e     = apply;
        if (cfg_load) begin
            p_fc = fc_word; p_kf = int'(kf); p_tw = tone_word; pend_on = 1;
        end else if (apply) pend_on = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        if (rst_n) begin
            chk("dac_data", dac_data, n < 2 ? 512 : dds(accv(n-3)));
            chk("dac_valid", dac_valid, n >= 7);
            chk("phase_wrap", phase_wrap, wrap_h[n]);
            chk("cfg_ack", cfg_ack, ack_e);
            wraps += int'(phase_wrap);
            acks  += int'(cfg_ack);
            bad   += int'(dac_data < 10'd1 || dac_data > 10'd1023);
        end else begin
            chk("rst_dac_data", dac_data, 512);
            chk("rst_dac_valid", dac_valid, 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        cfg_load = 1'b0;
        #1;
        chk("async_rst_dac_data", dac_data, 512);
        chk("async_rst_dac_valid", dac_valid, 0);
        chk("async_rst_wrap", phase_wrap, 0);
        chk("async_rst_ack", cfg_ack, 0);
        model_reset();
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        rst_n = 1'b1; mod_in = 10'd512; mode = 1'b0;
        fc_word = 32'd0; kf = 16'd0; tone_word = 32'd0; cfg_load = 1'b0;
        model_reset();
        do_reset(3);

        // plain carrier, zero deviation
        fc_word = 32'h1000_0000; kf = 16'h0100; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        acks = 0;
        repeat (40) tick();
        chk("t1_ack_count", acks, 1);
        wraps = 0;
        repeat (64) tick();
        chk("t1_wraps_per_64", wraps, 4);
        total = 0;
        repeat (16) begin tick(); total += int'(dac_data); end
        chk("t1_period_sum", total, 16 * 512);

        // modulating step
        mod_in = 10'd612;
        repeat (20) tick();

        // two loads between wraps collapse into one acknowledge
        k = 0;
        do begin tick(); k++; end while (!phase_wrap && k < 64);
        chk("t3_wrap_seen", phase_wrap, 1);
        fc_word = 32'h0800_0000; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        fc_word = 32'h2000_0000; cfg_load = 1'b1;
        acks = 0;
        tick();
        cfg_load = 1'b0;
        repeat (40) tick();
        chk("t3_single_ack", acks, 1);

        // internal triangle tone over more than a full tone period
        mode = 1'b1; tone_word = 32'h0010_0000; kf = 16'h4000; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (4300) tick();

        // extreme deviation with zero carrier
        mode = 1'b0; mod_in = 10'd0; fc_word = 32'd0; kf = 16'hFFFF; tone_word = 32'd0; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        bad = 0;
        repeat (40) tick();
        mod_in = 10'd1023;
        repeat (40) tick();
        chk("t5_range_violations", bad, 0);

        // reset while a config is pending
        fc_word = 32'h0300_0000; kf = 16'h0100; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        repeat (20) tick();
        fc_word = 32'h0500_0000; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        do_reset(3);
        acks = 0;
        repeat (20) tick();
        chk("t6_no_stale_ack", acks, 0);

        // randomized traffic
        repeat (600) begin
            mod_in = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            cfg_load = ($urandom_range(0, 9) == 0);
            if (cfg_load) begin
                fc_word   = $urandom;
                kf        = 16'($urandom);
                tone_word = $urandom_range(0, 32'h0040_0000);
            end
            tick();
        end
        cfg_load = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
